// File: rtl/dspm_dma.sv
// DSPM DMA: moves words between valid/ready streams and the scratchpad bus.
// Define DSPM_DMA_ADDR_WRAP_EN to let transfers wrap from 4095 to 0.
module dspm_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_start,
    input  logic        io_dir,
    input  logic [11:0] io_base,
    input  logic [11:0] io_len,
    output logic        io_busy,
    output logic        io_done,
    output logic        io_err,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_in_data,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_data,
    output logic [11:0] io_bus_addr,
    output logic        io_bus_enable,
    output logic        io_bus_byte_write_0,
    output logic        io_bus_byte_write_1,
    output logic        io_bus_byte_write_2,
    output logic        io_bus_byte_write_3,
    output logic [31:0] io_bus_data_in,
    input  logic [31:0] io_bus_data_out
);
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t      r_state;
    logic [11:0] r_addr;
    logic [12:0] r_rem;
    logic        r_err;
    logic        r_inflight;
    logic [31:0] r_fifo [2];
    logic        r_wp;
    logic        r_rp;
    logic [1:0]  r_cnt;

    logic        w_rem_nz;
    logic        w_wr_hs;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_occ;
    logic        w_rd_issue;
    logic        w_range_bad;
    logic        w_accept;
    logic        w_wr_done;
    logic        w_rd_done;

`ifdef DSPM_DMA_ADDR_WRAP_EN
    assign w_range_bad = 1'b0;
`else
    assign w_range_bad = ({1'b0, io_base} + {1'b0, io_len}) > 13'd4095;
`endif

    assign w_rem_nz   = (r_rem != 13'd0);
    assign w_wr_hs    = (r_state == S_WRITE) && w_rem_nz && io_in_valid;
    assign w_pop      = io_out_valid && io_out_ready;
    assign w_push     = r_inflight;
    // Occupancy after this cycle's pop lets reads stream back-to-back.
    assign w_occ      = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_rd_issue = (r_state == S_READ) && w_rem_nz && (w_occ <= 2'd1);
    assign w_accept   = (r_state == S_IDLE) && io_start && !w_range_bad;
    assign w_wr_done  = (r_state == S_WRITE) && !w_rem_nz;
    assign w_rd_done  = (r_state == S_READ) && !w_rem_nz &&
                        !r_inflight && (r_cnt == 2'd0);

    assign io_busy             = (r_state != S_IDLE);
    assign io_done             = w_wr_done || w_rd_done;
    assign io_err              = r_err;
    assign io_in_ready         = (r_state == S_WRITE) && w_rem_nz;
    assign io_out_valid        = (r_state == S_READ) && (r_cnt != 2'd0);
    assign io_out_data         = io_out_valid ? r_fifo[r_rp] : 32'd0;
    assign io_bus_addr         = r_addr;
    assign io_bus_enable       = w_wr_hs || w_rd_issue;
    assign io_bus_byte_write_0 = w_wr_hs;
    assign io_bus_byte_write_1 = w_wr_hs;
    assign io_bus_byte_write_2 = w_wr_hs;
    assign io_bus_byte_write_3 = w_wr_hs;
    assign io_bus_data_in      = (r_state == S_WRITE) ? io_in_data : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= 12'd0;
            r_rem      <= 13'd0;
            r_err      <= 1'b0;
            r_inflight <= 1'b0;
            r_fifo[0]  <= 32'd0;
            r_fifo[1]  <= 32'd0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_err      <= (r_state == S_IDLE) && io_start && w_range_bad;
            r_inflight <= w_rd_issue;
            if (w_push) begin
                r_fifo[r_wp] <= io_bus_data_out;
                r_wp         <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= io_dir ? S_READ : S_WRITE;
                        r_addr  <= io_base;
                        r_rem   <= {1'b0, io_len} + 13'd1;
                    end
                end
                S_WRITE: begin
                    if (w_wr_hs) begin
                        r_addr <= r_addr + 12'd1;
                        r_rem  <= r_rem - 13'd1;
                    end else if (w_wr_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (w_rd_issue) begin
                        r_addr <= r_addr + 12'd1;
                        r_rem  <= r_rem - 13'd1;
                    end else if (w_rd_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
